// File: rtl/ctrl_pkt_pkg.sv
// Control-packet layout shared by the config transmitter and the stage-side parsers.
// Field offsets index into the 512-bit header beat.
package ctrl_pkt_pkg;

    localparam int CTRL_DATA_W  = 512;

    localparam int UDP_PORT_OFF = 320;
    localparam int VID_OFF      = 360;
    localparam int MODID_OFF    = 368;
    localparam int IDX_OFF      = 376;

    localparam logic [2:0] RES_KEY_OFF  = 3'd0;
    localparam logic [2:0] RES_KEY_MASK = 3'd1;
    localparam logic [2:0] RES_CAM      = 3'd2;
    localparam logic [2:0] RES_ACT_RAM  = 3'd3;

    localparam logic [15:0] CTRL_PKT_LEN = 16'd128;

    // Bits [367:364] stay zero: the VID field is only 4 bits wide.
    function automatic logic [CTRL_DATA_W-1:0] build_hdr(
        input logic [15:0] udp_port,
        input logic [7:0]  mod_id,
        input logic [3:0]  vid,
        input logic [7:0]  index
    );
        logic [CTRL_DATA_W-1:0] w_hdr;
        w_hdr = '0;
        w_hdr[UDP_PORT_OFF +: 16] = udp_port;
        w_hdr[VID_OFF      +: 4]  = vid;
        w_hdr[MODID_OFF    +: 8]  = mod_id;
        w_hdr[IDX_OFF      +: 8]  = index;
        return w_hdr;
    endfunction

endpackage

// File: rtl/ctrl_cfg_tx.sv
// Serialises single table-write requests into two-beat control packets (header, payload)
// and enforces an idle gap after each packet, since the control chain has no tready.
module ctrl_cfg_tx
    import ctrl_pkt_pkg::*;
#(
    parameter int          C_S_AXIS_DATA_WIDTH  = 512,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          GAP_CYCLES           = 4,
    parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [7:0]                        cfg_mod_id,
    input  logic [3:0]                        cfg_vid,
    input  logic [7:0]                        cfg_index,
    input  logic [511:0]                      cfg_data,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    output logic [31:0]                       pkt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_GAP
    } tx_state_t;

    localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    tx_state_t                          r_state;
    logic [7:0]                         r_gap_cnt;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     r_data;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     r_tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]    r_tuser;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]   r_tkeep;
    logic                               r_tvalid;
    logic                               r_tlast;
    logic [31:0]                        r_pkt_cnt;

    // Beat registers are loaded one state ahead, so HDR/PAY each drive their beat
    // for exactly the cycle the FSM sits in that state.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_data    <= '0;
            r_tdata   <= '0;
            r_tuser   <= '0;
            r_tkeep   <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_data          <= cfg_data;
                        r_tdata         <= build_hdr(CTRL_UDP_PORT, cfg_mod_id, cfg_vid, cfg_index);
                        r_tuser         <= '0;
                        r_tuser[15:0]   <= CTRL_PKT_LEN;
                        r_tkeep         <= '1;
                        r_tvalid        <= 1'b1;
                        r_tlast         <= 1'b0;
                        r_state         <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    r_tdata   <= r_data;
                    r_tuser   <= '0;
                    r_tkeep   <= '1;
                    r_tvalid  <= 1'b1;
                    r_tlast   <= 1'b1;
                    r_pkt_cnt <= r_pkt_cnt + 32'd1;
                    r_state   <= ST_PAY;
                end
                ST_PAY: begin
                    r_tdata   <= '0;
                    r_tuser   <= '0;
                    r_tkeep   <= '0;
                    r_tvalid  <= 1'b0;
                    r_tlast   <= 1'b0;
                    r_gap_cnt <= GAP_LOAD;
                    r_state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
                ST_GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready       = (r_state == ST_IDLE);
    assign c_m_axis_tdata  = r_tdata;
    assign c_m_axis_tuser  = r_tuser;
    assign c_m_axis_tkeep  = r_tkeep;
    assign c_m_axis_tvalid = r_tvalid;
    assign c_m_axis_tlast  = r_tlast;
    assign pkt_cnt         = r_pkt_cnt;

endmodule

// File: tb/tb_ctrl_cfg_tx.sv
// Bench for ctrl_cfg_tx: two instances (gap 4 and gap 0) share one request stream and are
// checked every cycle against a timeline model built from accept cycles.
module tb_ctrl_cfg_tx;

    localparam int G0 = 4;
    localparam int G1 = 0;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         cfg_valid = 1'b0;
    logic [7:0]   cfg_mod_id = '0;
    logic [3:0]   cfg_vid = '0;
    logic [7:0]   cfg_index = '0;
    logic [511:0] cfg_data = '0;

    logic         cfg_ready [2];
    logic [511:0] tdata     [2];
    logic [127:0] tuser     [2];
    logic [63:0]  tkeep     [2];
    logic         tvalid    [2];
    logic         tlast     [2];
    logic [31:0]  pkt_cnt   [2];

    ctrl_cfg_tx #(.GAP_CYCLES(G0)) u_dut0 (
        .axis_clk(clk), .aresetn(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[0]),
        .cfg_mod_id(cfg_mod_id), .cfg_vid(cfg_vid), .cfg_index(cfg_index), .cfg_data(cfg_data),
        .c_m_axis_tdata(tdata[0]), .c_m_axis_tuser(tuser[0]), .c_m_axis_tkeep(tkeep[0]),
        .c_m_axis_tvalid(tvalid[0]), .c_m_axis_tlast(tlast[0]), .pkt_cnt(pkt_cnt[0])
    );

    ctrl_cfg_tx #(.GAP_CYCLES(G1)) u_dut1 (
        .axis_clk(clk), .aresetn(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[1]),
        .cfg_mod_id(cfg_mod_id), .cfg_vid(cfg_vid), .cfg_index(cfg_index), .cfg_data(cfg_data),
        .c_m_axis_tdata(tdata[1]), .c_m_axis_tuser(tuser[1]), .c_m_axis_tkeep(tkeep[1]),
        .c_m_axis_tvalid(tvalid[1]), .c_m_axis_tlast(tlast[1]), .pkt_cnt(pkt_cnt[1])
    );

    // scoreboard / model state
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           gap_of   [2] = '{G0, G1};
    int           acc_cyc  [2] = '{-100, -100};
    int           free_cyc [2] = '{0, 0};
    int           n_acc    [2] = '{0, 0};
    logic [511:0] m_hdr    [2];
    logic [511:0] m_pay    [2];
    logic [31:0]  m_cnt    [2] = '{32'd0, 32'd0};
    int           acc0_q[$];
    int           acc1_q[$];
    logic         force_now = 1'b0;
    logic         force_done = 1'b0;
    int           wrap_acc = -1;
    logic         pin_b0 = 1'b0;
    logic         pin_b1 = 1'b0;

    task automatic chk(input string name, input int g, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, g, cyc, act, exp);
        end
    endtask

    function automatic logic [511:0] hdr_of(input logic [7:0] m, input logic [3:0] v, input logic [7:0] x);
        logic [511:0] h;
        h = '0;
        h[335:320] = 16'hf1f2;
        h[363:360] = v;
        h[375:368] = m;
        h[383:376] = x;
        return h;
    endfunction

    // compare process: outputs are sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                acc_cyc[g]  = -100;
                free_cyc[g] = cyc;
                m_cnt[g]    = 32'd0;
            end else if (cyc == acc_cyc[g] + 2) begin
                m_cnt[g] = m_cnt[g] + 32'd1;
            end
        end

        for (int g = 0; g < 2; g++) begin
            logic         ev;
            logic         b1;
            logic [511:0] et;
            ev = rst_n && (cyc == acc_cyc[g] + 1 || cyc == acc_cyc[g] + 2);
            b1 = rst_n && (cyc == acc_cyc[g] + 2);
            et = !ev ? 512'd0 : (b1 ? m_pay[g] : m_hdr[g]);
            chk("tvalid", g, 512'(tvalid[g]), 512'(ev));
            chk("tlast", g, 512'(tlast[g]), 512'(b1));
            chk("tdata", g, tdata[g], et);
            chk("tuser", g, 512'(tuser[g]), (ev && !b1) ? 512'd128 : 512'd0);
            chk("tkeep", g, 512'(tkeep[g]), ev ? 512'(64'hffff_ffff_ffff_ffff) : 512'd0);
            chk("cfg_ready", g, 512'(cfg_ready[g]), 512'(cyc >= free_cyc[g]));
            chk("pkt_cnt", g, 512'(pkt_cnt[g]), 512'(m_cnt[g]));

            // hand-computed expectations for the very first packet
            if (n_acc[g] == 1 && cyc == acc_cyc[g] + 1) begin
                chk("pin_modid", g, 512'(tdata[g][375:368]), 512'(8'h0A));
                chk("pin_vid", g, 512'(tdata[g][363:360]), 512'(4'd3));
                chk("pin_idx", g, 512'(tdata[g][383:376]), 512'(8'h05));
                chk("pin_port", g, 512'(tdata[g][335:320]), 512'(16'hf1f2));
                chk("pin_tuser", g, 512'(tuser[g]), 512'd128);
                chk("pin_tlast0", g, 512'(tlast[g]), 512'd0);
            end
            if (n_acc[g] == 1 && cyc == acc_cyc[g] + 2) begin
                chk("pin_data", g, tdata[g], 512'h1234);
                chk("pin_tlast1", g, 512'(tlast[g]), 512'd1);
                chk("pin_cnt1", g, 512'(pkt_cnt[g]), 512'd1);
            end
        end

        if (g0_wrap_due()) chk("pin_wrap", 0, 512'(pkt_cnt[0]), 512'd0);

        if (!pin_b0 && acc0_q.size() >= 4) begin
            pin_b0 = 1'b1;
            chk("pin_period_gap4_a", 0, 512'(acc0_q[2] - acc0_q[1]), 512'd7);
            chk("pin_period_gap4_b", 0, 512'(acc0_q[3] - acc0_q[2]), 512'd7);
        end
        if (!pin_b1 && acc1_q.size() >= 3) begin
            pin_b1 = 1'b1;
            chk("pin_period_gap0", 1, 512'(acc1_q[2] - acc1_q[1]), 512'd3);
        end

        // acceptance for the coming rising edge
        for (int g = 0; g < 2; g++) begin
            if (rst_n && cfg_valid && cyc >= free_cyc[g]) begin
                acc_cyc[g]  = cyc;
                free_cyc[g] = cyc + 3 + gap_of[g];
                m_hdr[g]    = hdr_of(cfg_mod_id, cfg_vid, cfg_index);
                m_pay[g]    = cfg_data;
                n_acc[g]++;
                if (g == 0 && force_done && wrap_acc < 0) wrap_acc = cyc;
            end
        end
        if (rst_n && cfg_valid && cfg_ready[0]) acc0_q.push_back(cyc);
        if (rst_n && cfg_valid && cfg_ready[1]) acc1_q.push_back(cyc);

        if (force_now && !force_done) begin
            force u_dut0.r_pkt_cnt = 32'hffff_ffff;
            #1;
            release u_dut0.r_pkt_cnt;
            m_cnt[0]   = 32'hffff_ffff;
            force_done = 1'b1;
        end
    end

    function automatic logic g0_wrap_due();
        return (wrap_acc >= 0) && (cyc == wrap_acc + 2);
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 16; i++) cfg_data[i*32 +: 32] = $urandom;
    endtask

    task automatic rand_fields();
        cfg_mod_id = 8'($urandom_range(0, 255));
        cfg_vid    = 4'($urandom_range(0, 15));
        cfg_index  = 8'($urandom_range(0, 255));
        rand_data();
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // single request, payload changed right after accept
        cfg_valid  = 1'b1;
        cfg_mod_id = 8'h0A;
        cfg_vid    = 4'd3;
        cfg_index  = 8'd5;
        cfg_data   = 512'h1234;
        step();
        cfg_valid = 1'b0;
        rand_data();
        step();
        rand_data();
        repeat (10) step();

        // valid held high: back-to-back packets at the minimum period
        cfg_valid  = 1'b1;
        cfg_mod_id = 8'h13;
        cfg_vid    = 4'd7;
        cfg_index  = 8'hff;
        for (int i = 0; i < 15; i++) begin
            rand_data();
            step();
        end
        cfg_valid = 1'b0;
        repeat (10) step();

        // reset while the payload beat is on the bus
        rand_fields();
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        rand_fields();
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (10) step();

        // packet counter wrap
        force_now = 1'b1;
        repeat (2) step();
        rand_fields();
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (10) step();

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            cfg_valid = 1'($urandom_range(0, 1));
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        repeat (10) step();

        if (wrap_acc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wrap_accept got=none want=accept");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
